// File: rtl/exp_acc_pkg.sv
// Shared constants, FSM state type and sum-width helper for the exp frame accumulator.
package exp_acc_pkg;
  localparam int DATA_W      = 20;
  localparam int DEF_VEC_LEN = 16;
  localparam int DEF_SAT_W   = 22;

  typedef enum logic {IDLE, ACC} state_t;

  // Width that holds vl maximal dw-bit values without overflow.
  function automatic int sum_w(input int dw, input int vl);
    return dw + $clog2(vl);
  endfunction
endpackage

// File: rtl/exp_frame_acc_if.sv
// Sample stream in / frame result out bundle between exp stage and frame accumulator.
interface exp_frame_acc_if #(
  parameter int DATA_W = 20,
  parameter int SUM_W  = 24,
  parameter int CNT_W  = 5
);
  logic [DATA_W-1:0] iData;
  logic              iDataValid;
  logic              iLast;
  logic              iClear;
  logic [SUM_W-1:0]  oSum;
  logic              oSumValid;
  logic [CNT_W-1:0]  oCount;
  logic              oOverflow;

  modport master (output iData, iDataValid, iLast, iClear,
                  input  oSum, oSumValid, oCount, oOverflow);
  modport slave  (input  iData, iDataValid, iLast, iClear,
                  output oSum, oSumValid, oCount, oOverflow);
endinterface

// File: rtl/exp_acc_frame_cnt.sv
// Frame element counter and IDLE/ACC FSM; flags the sample that closes a frame.
module exp_acc_frame_cnt
  import exp_acc_pkg::*;
#(
  parameter int VEC_LEN = DEF_VEC_LEN,
  parameter int CNT_W   = $clog2(VEC_LEN+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic             i_last,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_close
);
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_accept;

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_accept  = i_valid & ~i_clear;
  // Reaching VEC_LEN forces a close so the count can never wrap.
  assign o_close   = w_accept & (i_last | (w_cnt_inc == CNT_W'(VEC_LEN)));
  assign o_cnt     = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept && !o_close) begin
            r_state <= ACC;
            r_cnt   <= w_cnt_inc;
          end
        end
        ACC: begin
          if (i_clear || o_close) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (w_accept) begin
            r_cnt   <= w_cnt_inc;
          end
        end
      endcase
    end
  end
endmodule

// File: rtl/exp_frame_acc.sv
// Softmax denominator accumulator: sums a frame of exp samples, pulses sum/count/overflow at close.
// Optional EXP_ACC_SAT_EN: SAT_W-bit saturating accumulator with sticky per-frame overflow flag.
module exp_frame_acc #(
  parameter int DATA_W  = exp_acc_pkg::DATA_W,
  parameter int VEC_LEN = exp_acc_pkg::DEF_VEC_LEN,
  parameter int SUM_W   = exp_acc_pkg::sum_w(DATA_W, VEC_LEN),
  parameter int CNT_W   = $clog2(VEC_LEN+1)
`ifdef EXP_ACC_SAT_EN
  , parameter int SAT_W = exp_acc_pkg::DEF_SAT_W
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  exp_frame_acc_if.slave  bus
);
`ifdef EXP_ACC_SAT_EN
  localparam int ACC_W = SAT_W;
`else
  localparam int ACC_W = SUM_W;
`endif

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [SUM_W-1:0] r_sum;
  logic [CNT_W-1:0] r_count;
  logic             r_sum_vld;
  logic [CNT_W-1:0] w_cnt;
  logic             w_close;

  exp_acc_frame_cnt #(.VEC_LEN(VEC_LEN), .CNT_W(CNT_W)) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (bus.iDataValid),
    .i_last  (bus.iLast),
    .i_clear (bus.iClear),
    .o_cnt   (w_cnt),
    .o_close (w_close)
  );

`ifdef EXP_ACC_SAT_EN
  logic [ACC_W:0] w_raw;
  logic           w_ovf_nxt;
  logic           r_ovf;
  logic           r_ovf_o;

  assign w_raw     = {1'b0, r_acc} + (ACC_W+1)'(bus.iData);
  assign w_acc_nxt = w_raw[ACC_W] ? '1 : w_raw[ACC_W-1:0];
  assign w_ovf_nxt = r_ovf | w_raw[ACC_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf   <= 1'b0;
      r_ovf_o <= 1'b0;
    end else begin
      if (bus.iClear || w_close) r_ovf <= 1'b0;
      else if (bus.iDataValid)   r_ovf <= w_ovf_nxt;
      if (w_close) r_ovf_o <= w_ovf_nxt;
    end
  end

  assign bus.oOverflow = r_ovf_o;
`else
  // SUM_W is wide enough for a full frame of maximal samples, so no overflow is possible.
  assign w_acc_nxt     = r_acc + ACC_W'(bus.iData);
  assign bus.oOverflow = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_sum     <= '0;
      r_count   <= '0;
      r_sum_vld <= 1'b0;
    end else begin
      r_sum_vld <= w_close;
      if (bus.iClear || w_close) r_acc <= '0;
      else if (bus.iDataValid)   r_acc <= w_acc_nxt;
      if (w_close) begin
        r_sum   <= SUM_W'(w_acc_nxt);
        r_count <= w_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.oSum      = r_sum;
  assign bus.oCount    = r_count;
  assign bus.oSumValid = r_sum_vld;
endmodule

// File: tb/tb_exp_frame_acc.sv
// Randomized and directed bench for exp_frame_acc against a per-frame arithmetic model.
module tb_exp_frame_acc;
  localparam int DW = exp_acc_pkg::DATA_W;
  localparam int VL = exp_acc_pkg::DEF_VEC_LEN;
  localparam int SW = exp_acc_pkg::sum_w(DW, VL);
  localparam int CW = $clog2(VL+1);
  localparam longint SAT_MAX = (longint'(1) << exp_acc_pkg::DEF_SAT_W) - 1;
`ifdef EXP_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  exp_frame_acc_if #(.DATA_W(DW), .SUM_W(SW), .CNT_W(CW)) bus ();
  exp_frame_acc dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  longint m_acc = 0;
  int     m_cnt = 0;
  bit     m_ovf = 1'b0;
  longint e_sum = 0;
  int     e_cnt = 0;
  bit     e_vld = 1'b0;
  bit     e_ovf = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_vld"}, 64'(bus.oSumValid), 64'(e_vld));
    chk({tag, "_sum"}, 64'(bus.oSum),      64'(e_sum));
    chk({tag, "_cnt"}, 64'(bus.oCount),    64'(e_cnt));
    chk({tag, "_ovf"}, 64'(bus.oOverflow), 64'(e_ovf));
  endtask

  task automatic model_clear();
    m_acc = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  // One clock edge of frame semantics: clear wins, then accumulate, then close on last/full.
  task automatic model(input bit v, input logic [DW-1:0] d, input bit last, input bit clr);
    e_vld = 1'b0;
    if (clr) model_clear();
    else if (v) begin
      m_acc += longint'(d);
      m_cnt++;
      if (SAT && m_acc > SAT_MAX) begin
        m_acc = SAT_MAX;
        m_ovf = 1'b1;
      end
      if (last || m_cnt == VL) begin
        e_vld = 1'b1;
        e_sum = m_acc;
        e_cnt = m_cnt;
        e_ovf = m_ovf;
        model_clear();
      end
    end
  endtask

  task automatic step(input bit v, input logic [DW-1:0] d, input bit last, input bit clr,
                      input string tag);
    @(negedge clk);
    bus.iDataValid = v;
    bus.iData      = d;
    bus.iLast      = last;
    bus.iClear     = clr;
    @(posedge clk);
    model(v, d, last, clr);
    #1 check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n          = 1'b0;
    bus.iDataValid = 1'b0;
    bus.iData      = '0;
    bus.iLast      = 1'b0;
    bus.iClear     = 1'b0;
    #1;
    model_clear();
    e_sum = 0; e_cnt = 0; e_vld = 1'b0; e_ovf = 1'b0;
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.iDataValid = 1'b0;
    bus.iData      = '0;
    bus.iLast      = 1'b0;
    bus.iClear     = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_all("rst0");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0, "idle");

    // Full frame auto-closes at VEC_LEN without iLast
    for (int i = 0; i < VL; i++) step(1'b1, DW'('h100), 1'b0, 1'b0, "full");
    chk("full_sum_k", 64'(bus.oSum), 64'h1000);
    chk("full_cnt_k", 64'(bus.oCount), 64'd16);
    step(1'b0, '0, 1'b0, 1'b0, "full_after");

    step(1'b1, DW'(1), 1'b0, 1'b0, "f3");
    step(1'b1, DW'(2), 1'b0, 1'b0, "f3");
    step(1'b1, DW'(3), 1'b1, 1'b0, "f3");
    chk("f3_sum_k", 64'(bus.oSum), 64'd6);
    chk("f3_cnt_k", 64'(bus.oCount), 64'd3);

    // Back-to-back frames, no bubble
    step(1'b1, DW'(5), 1'b1, 1'b0, "fa");
    chk("fa_sum_k", 64'(bus.oSum), 64'd5);
    step(1'b1, DW'(7), 1'b0, 1'b0, "fb");
    step(1'b1, DW'(9), 1'b1, 1'b0, "fb");
    chk("fb_sum_k", 64'(bus.oSum), 64'd16);
    chk("fb_cnt_k", 64'(bus.oCount), 64'd2);

    step(1'b1, DW'('h10), 1'b0, 1'b0, "clr");
    step(1'b1, DW'('h10), 1'b0, 1'b0, "clr");
    step(1'b1, DW'('h20), 1'b0, 1'b1, "clr");
    step(1'b0, DW'('h55), 1'b1, 1'b0, "last_novld");
    step(1'b1, DW'(1), 1'b1, 1'b0, "clr");
    chk("clr_sum_k", 64'(bus.oSum), 64'd1);
    chk("clr_cnt_k", 64'(bus.oCount), 64'd1);

    for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0, "prerst");
    do_reset("midrst");
    step(1'b1, DW'(3), 1'b0, 1'b0, "postrst");
    step(1'b1, DW'(4), 1'b1, 1'b0, "postrst");
    chk("postrst_sum_k", 64'(bus.oSum), 64'd7);

    for (int i = 0; i < VL; i++) step(1'b1, DW'('hFFFFF), 1'b0, 1'b0, "max");
`ifdef EXP_ACC_SAT_EN
    chk("sat_sum_k", 64'(bus.oSum), 64'h3FFFFF);
    chk("sat_ovf_k", 64'(bus.oOverflow), 64'd1);
    step(1'b1, DW'(1), 1'b1, 1'b0, "sat_next");
    chk("sat_next_ovf_k", 64'(bus.oOverflow), 64'd0);
`else
    chk("max_sum_k", 64'(bus.oSum), 64'hFFFFF0);
    chk("max_ovf_k", 64'(bus.oOverflow), 64'd0);
`endif

    for (int i = 0; i < 500; i++) begin
      logic [DW-1:0] d;
      d = ($urandom_range(0, 7) == 0) ? DW'('hFFFFF) : DW'($urandom);
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 5) == 0,
           $urandom_range(0, 24) == 0, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
